// File: rtl/jk_excitation_gen.sv
`default_nettype none
// ============================================================================
// Module      : jk_excitation_gen
// Description : Turns a stream of D-style target states into J/K excitation
//               vectors for an external JK flip-flop bank, with a shadow copy
//               of the bank state and a 2-entry valid/ready output buffer.
//               Optional macro JK_CHG_CNT_EN adds a saturating CHG_CNT output.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_excitation_gen #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               DC_VAL    = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             JK_VALID,
    input  logic             JK_READY,
    output logic [WIDTH-1:0] Q_OUT,
    output logic [1:0]       PEND
`ifdef JK_CHG_CNT_EN
    ,
    output logic [15:0]      CHG_CNT
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] head_j_q, head_j_d;
    logic [WIDTH-1:0] head_k_q, head_k_d;
    logic [WIDTH-1:0] tail_j_q, tail_j_d;
    logic [WIDTH-1:0] tail_k_q, tail_k_d;
    logic [WIDTH-1:0] new_j, new_k;
    logic             accept, pop;

    // Excitation is always taken against the shadow, i.e. the previous target.
    always_comb begin
        new_j = '0;
        new_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case ({shadow_q[i], D[i]})
                2'b00:   begin new_j[i] = 1'b0;   new_k[i] = DC_VAL; end
                2'b01:   begin new_j[i] = 1'b1;   new_k[i] = DC_VAL; end
                2'b10:   begin new_j[i] = DC_VAL; new_k[i] = 1'b1;   end
                default: begin new_j[i] = DC_VAL; new_k[i] = 1'b0;   end
            endcase
        end
    end

    assign D_READY  = (state_q != S_TWO);
    assign JK_VALID = (state_q != S_EMPTY);
    assign accept   = D_VALID & D_READY;
    assign pop      = JK_VALID & JK_READY;

    always_comb begin
        state_d  = state_q;
        head_j_d = head_j_q;
        head_k_d = head_k_q;
        tail_j_d = tail_j_q;
        tail_k_d = tail_k_q;
        shadow_d = accept ? D : shadow_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    head_j_d = new_j;
                    head_k_d = new_k;
                    state_d  = S_ONE;
                end
            end
            S_ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        tail_j_d = new_j;
                        tail_k_d = new_k;
                        state_d  = S_TWO;
                    end
                    2'b01: begin
                        state_d = S_EMPTY;
                    end
                    2'b11: begin
                        head_j_d = new_j;
                        head_k_d = new_k;
                    end
                    default: begin
                    end
                endcase
            end
            S_TWO: begin
                if (pop) begin
                    head_j_d = tail_j_q;
                    head_k_d = tail_k_q;
                    state_d  = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_EMPTY;
            shadow_q <= RESET_VAL;
            head_j_q <= '0;
            head_k_q <= '0;
            tail_j_q <= '0;
            tail_k_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            head_j_q <= head_j_d;
            head_k_q <= head_k_d;
            tail_j_q <= tail_j_d;
            tail_k_q <= tail_k_d;
        end
    end

    assign J     = head_j_q;
    assign K     = head_k_q;
    assign Q_OUT = shadow_q;
    assign PEND  = state_q;

`ifdef JK_CHG_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    // A bit is counted whenever the popped entry drives J or K high on it.
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_sum = cnt_sum + 17'(head_j_q[i] | head_k_q[i]);
        end
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CHG_CNT = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_excitation_gen
// Description : Scoreboard bench for jk_excitation_gen; two instances
//               (DC_VAL=0 and DC_VAL=1) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_excitation_gen;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b0000;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] D;
    logic         D_VALID;
    logic         JK_READY;

    logic         rdy0, rdy1, v0, v1;
    logic [W-1:0] j0, k0, j1, k1, q0, q1;
    logic [1:0]   p0, p1;
`ifdef JK_CHG_CNT_EN
    logic [15:0]  cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    jk_excitation_gen #(.WIDTH(W), .RESET_VAL(RV), .DC_VAL(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_READY(rdy0),
        .J(j0), .K(k0), .JK_VALID(v0), .JK_READY(JK_READY),
        .Q_OUT(q0), .PEND(p0)
`ifdef JK_CHG_CNT_EN
        , .CHG_CNT(cnt0)
`endif
    );

    jk_excitation_gen #(.WIDTH(W), .RESET_VAL(RV), .DC_VAL(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_READY(rdy1),
        .J(j1), .K(k1), .JK_VALID(v1), .JK_READY(JK_READY),
        .Q_OUT(q1), .PEND(p1)
`ifdef JK_CHG_CNT_EN
        , .CHG_CNT(cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference excitation from rise/fall masks; don't-care where the bank
    // state alone already decides the outcome.
    function automatic logic [7:0] ref_jk(input logic [3:0] q, input logic [3:0] d, input logic dc);
        logic [3:0] rise, fall, jv, kv;
        rise = ~q & d;
        fall = q & ~d;
        jv   = rise | (q & {4{dc}});
        kv   = fall | (~q & {4{dc}});
        return {jv, kv};
    endfunction

    function automatic logic [3:0] jk_apply(input logic [3:0] q, input logic [3:0] jv, input logic [3:0] kv);
        return (jv & ~q) | (~kv & q);
    endfunction

    // Scoreboard: each accepted transaction records {previous target, target}.
    logic [7:0] sb[$];
    logic [3:0] shadow = RV;
    logic [3:0] bank0  = RV;
    logic [3:0] bank1  = RV;
    int         cnt_model = 0;

    always @(negedge CLK) begin
        logic [7:0] e;
        logic [7:0] x0, x1;
        if (RST) begin
            sb.delete();
            shadow    = RV;
            bank0     = RV;
            bank1     = RV;
            cnt_model = 0;
        end else begin
            chk("pend0",   32'(p0),   32'(sb.size()));
            chk("pend1",   32'(p1),   32'(sb.size()));
            chk("valid0",  32'(v0),   32'(sb.size() != 0));
            chk("valid1",  32'(v1),   32'(sb.size() != 0));
            chk("dready0", 32'(rdy0), 32'(sb.size() != 2));
            chk("dready1", 32'(rdy1), 32'(sb.size() != 2));
            chk("qout0",   32'(q0),   32'(shadow));
            chk("qout1",   32'(q1),   32'(shadow));
`ifdef JK_CHG_CNT_EN
            chk("chgcnt0", 32'(cnt0), 32'(cnt_model));
`endif
            if (v0 && JK_READY) begin
                if (sb.size() == 0) begin
                    chk("pop_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    e  = sb.pop_front();
                    x0 = ref_jk(e[7:4], e[3:0], 1'b0);
                    x1 = ref_jk(e[7:4], e[3:0], 1'b1);
                    chk("j_dc0", 32'(j0), 32'(x0[7:4]));
                    chk("k_dc0", 32'(k0), 32'(x0[3:0]));
                    chk("j_dc1", 32'(j1), 32'(x1[7:4]));
                    chk("k_dc1", 32'(k1), 32'(x1[3:0]));
                    bank0 = jk_apply(bank0, j0, k0);
                    bank1 = jk_apply(bank1, j1, k1);
                    chk("bank0", 32'(bank0), 32'(e[3:0]));
                    chk("bank1", 32'(bank1), 32'(e[3:0]));
                    cnt_model = cnt_model + $countones(e[7:4] ^ e[3:0]);
                    if (cnt_model > 16'hFFFF) cnt_model = 16'hFFFF;
                end
            end
            if (D_VALID && rdy0) begin
                sb.push_back({shadow, D});
                shadow = D;
            end
        end
    end

    task automatic push(input logic [3:0] d);
        bit ok;
        ok      = 1'b0;
        D       = d;
        D_VALID = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (rdy0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        D_VALID = 1'b0;
    endtask

    task automatic drain();
        JK_READY = 1'b1;
        D_VALID  = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("drained", 32'(p0), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_q"},     32'(q0),   32'(RV));
        chk({tag, "_pend"},  32'(p0),   32'd0);
        chk({tag, "_valid"}, 32'(v0),   32'd0);
        chk({tag, "_ready"}, 32'(rdy0), 32'd1);
        chk({tag, "_j"},     32'(j0),   32'd0);
        chk({tag, "_k"},     32'(k1),   32'd0);
    endtask

    initial begin
        RST      = 1'b1;
        D        = '0;
        D_VALID  = 1'b0;
        JK_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outs("reset");
        RST = 1'b0;

        // Two chained pushes with a free downstream; the second one
        // coincides with a pop of the first.
        JK_READY = 1'b1;
        push(4'b1010);
        chk("t2_j0", 32'(j0), 32'b1010);
        chk("t2_k0", 32'(k0), 32'b0000);
        chk("t3_j1", 32'(j1), 32'b1010);
        chk("t3_k1", 32'(k1), 32'b1111);
        chk("t2_q",  32'(q0), 32'b1010);
        push(4'b0110);
        chk("t2b_j0",  32'(j0), 32'b0100);
        chk("t2b_k0",  32'(k0), 32'b1000);
        chk("t3b_j1",  32'(j1), 32'b1110);
        chk("t3b_k1",  32'(k1), 32'b1101);
        chk("t5_pend", 32'(p0), 32'd1);
        drain();

        // Back-pressure: third push held until the buffer frees.
        JK_READY = 1'b0;
        push(4'b1010);
        push(4'b0110);
        fork
            push(4'b0001);
            begin
                chk("t4_full",  32'(p0),   32'd2);
                chk("t4_ready", 32'(rdy0), 32'd0);
                repeat (3) @(posedge CLK);
                #1;
                chk("t4_held", 32'(q0), 32'b0110);
                JK_READY = 1'b1;
            end
        join
        drain();

        // Asynchronous reset while the buffer is full.
        JK_READY = 1'b0;
        push(4'b1100);
        push(4'b0011);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk_reset_outs("async");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int c = 0; c < 800; c++) begin
            @(posedge CLK);
            #1;
            D        = 4'($urandom);
            D_VALID  = ($urandom_range(0, 2) != 0);
            JK_READY = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        end
        D_VALID = 1'b0;
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
